// File: rtl/fpu_ret_collect.sv
// -----------------------------------------------------------------------------
// fpu_ret_collect
//
// Gathers completion words from the three FP SIMD/shuffle lanes (u1, u3, u5)
// into an in-order FIFO. Up to three completions are captured per cycle. One
// entry drains per cycle to retire over a valid/ready handshake. IEEE
// exception flags of drained entries accumulate into a sticky CSR field.
//
// Parameters:
//   DEPTH      - FIFO entries (power of two, >= 8)
//   STALL_FREE - stall is raised when fewer free entries than this remain
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   u{1,3,5}_ret / _ret_en / _II    - lane completion word, strobe, instr index
//   out_valid / out_ready           - head handshake toward retire
//   out_ret / out_II / out_unit     - head entry (unit: 0=u1, 1=u3, 2=u5)
//   stall                           - registered backpressure to issue
//   fl_we / fl_wdata                - CSR write of the flag field
//   fl_sticky                       - accumulated sticky NV,DZ,OF,UF,NX flags
//   count                           - occupancy
//   ovf                             - sticky overflow error
//
// Optional feature macro: FPU_RET_BYPASS_EN
//   When defined, a lone completion arriving at an empty FIFO is presented on
//   out_* in the same cycle and, if accepted, never occupies a slot.
// -----------------------------------------------------------------------------
module fpu_ret_collect #(
    parameter int DEPTH      = 16,
    parameter int STALL_FREE = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [13:0]              u1_ret,
    input  logic                     u1_ret_en,
    input  logic [9:0]               u1_II,
    input  logic [13:0]              u3_ret,
    input  logic                     u3_ret_en,
    input  logic [9:0]               u3_II,
    input  logic [13:0]              u5_ret,
    input  logic                     u5_ret_en,
    input  logic [9:0]               u5_II,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [13:0]              out_ret,
    output logic [9:0]               out_II,
    output logic [1:0]               out_unit,
    output logic                     stall,
    input  logic                     fl_we,
    input  logic [4:0]               fl_wdata,
    output logic [4:0]               fl_sticky,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 26;  // {unit[1:0], II[9:0], ret[13:0]}
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(STALL_FREE);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic [EW-1:0] w1, w3, w5;
    logic [EW-1:0] head;
    logic          fifo_pop, byp_pop, pop;
    logic [4:0]    pop_flags;
    logic          e1, e3, e5;
    logic [1:0]    slot3, slot5;
    logic          acc1, acc3, acc5, drop;
    logic [1:0]    n_acc;
    logic [CW-1:0] free_slots, count_next;

    assign w1 = {2'd0, u1_II, u1_ret};
    assign w3 = {2'd1, u3_II, u3_ret};
    assign w5 = {2'd2, u5_II, u5_ret};

    // A pop is judged on the pre-push occupancy, so an empty FIFO never pops.
    assign fifo_pop = (count != '0) && out_ready;

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0);
        byp_pop   = 1'b0;
`ifdef FPU_RET_BYPASS_EN
        if ((count == '0) &&
            ((2'(u1_ret_en) + 2'(u3_ret_en) + 2'(u5_ret_en)) == 2'd1)) begin
            head      = u1_ret_en ? w1 : (u3_ret_en ? w3 : w5);
            out_valid = 1'b1;
            byp_pop   = out_ready;
        end
`endif
    end

    // Outputs read as zero while nothing is valid, which also covers reset.
    assign out_ret   = out_valid ? head[13:0]  : '0;
    assign out_II    = out_valid ? head[23:14] : '0;
    assign out_unit  = out_valid ? head[25:24] : '0;
    assign pop       = fifo_pop | byp_pop;
    assign pop_flags = pop ? out_ret[4:0] : 5'd0;

    // A bypassed completion is consumed directly and never written.
    assign e1 = u1_ret_en & ~byp_pop;
    assign e3 = u3_ret_en & ~byp_pop;
    assign e5 = u5_ret_en & ~byp_pop;

    // Lanes pack into consecutive slots in u1, u3, u5 order; a lane whose slot
    // lies beyond the free space this cycle is dropped and flags overflow.
    assign slot3      = 2'(e1);
    assign slot5      = 2'(e1) + 2'(e3);
    assign free_slots = DEPTH_C - count + CW'(fifo_pop);
    assign acc1       = e1 && (free_slots != '0);
    assign acc3       = e3 && (CW'(slot3) < free_slots);
    assign acc5       = e5 && (CW'(slot5) < free_slots);
    assign drop       = (e1 & ~acc1) | (e3 & ~acc3) | (e5 & ~acc5);
    assign n_acc      = 2'(acc1) + 2'(acc3) + 2'(acc5);
    assign count_next = count + CW'(n_acc) - CW'(fifo_pop);

    // NOTE: storage has no reset; contents are don't-care once the pointers
    // clear, and a write landing during reset is orphaned by that clear.
    always_ff @(posedge clk) begin
        if (acc1) mem[wr_ptr]              <= w1;
        if (acc3) mem[wr_ptr + AW'(slot3)] <= w3;
        if (acc5) mem[wr_ptr + AW'(slot5)] <= w5;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fl_sticky <= '0;
            ovf       <= 1'b0;
            stall     <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(n_acc);
            rd_ptr    <= rd_ptr + AW'(fifo_pop);
            count     <= count_next;
            stall     <= (DEPTH_C - count_next) < STALL_C;
            ovf       <= ovf | drop;
            // A CSR write replaces the field but keeps the flags retiring now.
            fl_sticky <= fl_we ? (fl_wdata | pop_flags) : (fl_sticky | pop_flags);
        end
    end

endmodule

// File: tb/tb_fpu_ret_collect.sv
// -----------------------------------------------------------------------------
// tb_fpu_ret_collect
//
// Directed bench for fpu_ret_collect. A queue-based reference model tracks the
// expected FIFO contents, sticky flags, stall and overflow; a compare process
// checks the DUT against it every falling edge. Directed sections add literal
// expectations for reset, ordering, flag accumulation, stall threshold,
// overflow, pointer wrap and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_fpu_ret_collect;

    localparam int DEPTH      = 16;
    localparam int STALL_FREE = 6;

    typedef struct packed {
        logic [1:0]  unit;
        logic [9:0]  ii;
        logic [13:0] ret;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;
    logic [9:0]  u1_II, u3_II, u5_II;
    logic        out_valid, out_ready;
    logic [13:0] out_ret;
    logic [9:0]  out_II;
    logic [1:0]  out_unit;
    logic        stall;
    logic        fl_we;
    logic [4:0]  fl_wdata, fl_sticky;
    logic [4:0]  count;
    logic        ovf;

    fpu_ret_collect #(.DEPTH(DEPTH), .STALL_FREE(STALL_FREE)) dut (
        .clk(clk), .rst(rst),
        .u1_ret(u1_ret), .u1_ret_en(u1_ret_en), .u1_II(u1_II),
        .u3_ret(u3_ret), .u3_ret_en(u3_ret_en), .u3_II(u3_II),
        .u5_ret(u5_ret), .u5_ret_en(u5_ret_en), .u5_II(u5_II),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ret(out_ret), .out_II(out_II), .out_unit(out_unit),
        .stall(stall), .fl_we(fl_we), .fl_wdata(fl_wdata),
        .fl_sticky(fl_sticky), .count(count), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    ent_t       m_q[$];
    logic [4:0] m_sticky;
    logic       m_ovf;
    logic       m_stall;
    logic       live = 1'b0;

    function automatic ent_t lane_ent(input int k);
        case (k)
            0:       return '{unit: 2'd0, ii: u1_II, ret: u1_ret};
            1:       return '{unit: 2'd1, ii: u3_II, ret: u3_ret};
            default: return '{unit: 2'd2, ii: u5_II, ret: u5_ret};
        endcase
    endfunction

    function automatic logic lane_en(input int k);
        case (k)
            0:       return u1_ret_en;
            1:       return u3_ret_en;
            default: return u5_ret_en;
        endcase
    endfunction

    function automatic int n_strobes();
        return int'(u1_ret_en) + int'(u3_ret_en) + int'(u5_ret_en);
    endfunction

    // Index of the lone asserted lane (only meaningful when exactly one is set).
    function automatic int lone_lane();
        if (u1_ret_en) return 0;
        if (u3_ret_en) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_sticky = '0;
            m_ovf    = 1'b0;
            m_stall  = 1'b0;
            live     = 1'b1;
        end else if (live) begin
            logic [4:0] fl;
            logic       skip_push;
            fl        = '0;
            skip_push = 1'b0;
            if (m_q.size() != 0) begin
                if (out_ready) begin
                    fl = m_q[0].ret[4:0];
                    void'(m_q.pop_front());
                end
            end
`ifdef FPU_RET_BYPASS_EN
            else if (n_strobes() == 1 && out_ready) begin
                ent_t b;
                b         = lane_ent(lone_lane());
                fl        = b.ret[4:0];
                skip_push = 1'b1;
            end
`endif
            if (!skip_push) begin
                for (int k = 0; k < 3; k++) begin
                    if (lane_en(k)) begin
                        if (m_q.size() < DEPTH) m_q.push_back(lane_ent(k));
                        else m_ovf = 1'b1;
                    end
                end
            end
            m_sticky = fl_we ? (fl_wdata | fl) : (m_sticky | fl);
            m_stall  = (DEPTH - m_q.size()) < STALL_FREE;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (live) begin
            logic exp_valid;
            ent_t exp_head;
            exp_valid = (m_q.size() != 0);
            exp_head  = '0;
            if (exp_valid) exp_head = m_q[0];
`ifdef FPU_RET_BYPASS_EN
            else if (n_strobes() == 1) begin
                exp_valid = 1'b1;
                exp_head  = lane_ent(lone_lane());
            end
`endif
            check("m_count",  32'(count),     32'(m_q.size()));
            check("m_valid",  32'(out_valid), 32'(exp_valid));
            check("m_stall",  32'(stall),     32'(m_stall));
            check("m_sticky", 32'(fl_sticky), 32'(m_sticky));
            check("m_ovf",    32'(ovf),       32'(m_ovf));
            if (exp_valid && out_valid) begin
                check("m_ret",  32'(out_ret),  32'(exp_head.ret));
                check("m_II",   32'(out_II),   32'(exp_head.ii));
                check("m_unit", 32'(out_unit), 32'(exp_head.unit));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic e1, input logic e3, input logic e5,
                             input logic [9:0] i1, input logic [9:0] i3, input logic [9:0] i5,
                             input logic [4:0] f1, input logic [4:0] f3, input logic [4:0] f5);
        u1_ret_en = e1; u1_II = i1; u1_ret = {9'(i1 * 3), f1};
        u3_ret_en = e3; u3_II = i3; u3_ret = {9'(i3 * 5), f3};
        u5_ret_en = e5; u5_II = i5; u5_ret = {9'(i5 * 7), f5};
    endtask

    task automatic clear_lanes();
        u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; fl_we = 1'b0; fl_wdata = '0;
        set_lanes(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_ovf",   32'(ovf), 0);
        check("rst_flags", 32'(fl_sticky), 0);

        // Three lanes in one cycle, drained in u1, u3, u5 order
        set_lanes(1, 1, 1, 10'd5, 10'd6, 10'd7, 0, 0, 0);
        tick(); clear_lanes();
        check("t1_count", 32'(count), 3);
        check("t1_unit0", 32'(out_unit), 0);
        check("t1_II0",   32'(out_II), 5);
        out_ready = 1'b1;
        tick();
        check("t1_unit1", 32'(out_unit), 1);
        check("t1_II1",   32'(out_II), 6);
        tick();
        check("t1_unit2", 32'(out_unit), 2);
        check("t1_II2",   32'(out_II), 7);
        tick();
        check("t1_empty", 32'(count), 0);
        out_ready = 1'b0;

        // Flags accumulate only as entries drain
        set_lanes(0, 1, 0, 0, 10'd20, 0, 0, 5'b00001, 0);
        tick();
        set_lanes(0, 0, 1, 0, 0, 10'd21, 0, 0, 5'b10000);
        tick(); clear_lanes();
        check("t2_queued", 32'(fl_sticky), 0);
        out_ready = 1'b1;
        tick();
        check("t2_pop1", 32'(fl_sticky), 32'(5'b00001));
        tick();
        check("t2_pop2", 32'(fl_sticky), 32'(5'b10001));
        out_ready = 1'b0;

        // CSR write of zero coinciding with a flagged pop keeps the pop flags
        set_lanes(1, 0, 0, 10'd30, 0, 0, 5'b00100, 0, 0);
        tick(); clear_lanes();
        out_ready = 1'b1; fl_we = 1'b1; fl_wdata = 5'b00000;
        tick();
        fl_we = 1'b0; out_ready = 1'b0;
        check("t3_csr", 32'(fl_sticky), 32'(5'b00100));

        // Stall threshold and overflow
        for (int k = 0; k < 3; k++) begin
            set_lanes(1, 1, 1, 10'(200 + 3 * k), 10'(201 + 3 * k), 10'(202 + 3 * k),
                      5'(1 << k), 0, 5'(2 << k));
            tick();
        end
        clear_lanes();
        check("t4_cnt9",    32'(count), 9);
        check("t4_stall9",  32'(stall), 0);
        set_lanes(1, 0, 0, 10'd210, 0, 0, 0, 0, 0);
        tick();
        check("t4_stall10", 32'(stall), 0);
        set_lanes(1, 0, 0, 10'd211, 0, 0, 0, 0, 0);
        tick();
        check("t4_cnt11",   32'(count), 11);
        check("t4_stall11", 32'(stall), 1);
        set_lanes(1, 1, 1, 10'd212, 10'd213, 10'd214, 0, 0, 0);
        tick();
        set_lanes(1, 0, 0, 10'd215, 0, 0, 0, 0, 0);
        tick();
        check("t4_cnt15", 32'(count), 15);
        check("t4_ovf15", 32'(ovf), 0);
        set_lanes(1, 1, 1, 10'd216, 10'd217, 10'd218, 0, 0, 0);
        tick(); clear_lanes();
        check("t4_cnt16", 32'(count), 16);
        check("t4_ovf16", 32'(ovf), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        out_ready = 1'b0;
        check("t4_drained", 32'(count), 0);
        check("t4_ovfhold", 32'(ovf), 1);

        // Pointer wrap with single interleaved pushes and pops
        for (int i = 0; i < 20; i++) begin
            set_lanes(i % 3 == 0, i % 3 == 1, i % 3 == 2,
                      10'(100 + i), 10'(100 + i), 10'(100 + i),
                      5'(i), 5'(i), 5'(i));
            out_ready = (i >= 1);
            tick();
            check("t5_head", 32'(out_II), 32'(100 + i));
        end
        clear_lanes();
        tick();
        out_ready = 1'b0;
        check("t5_empty", 32'(count), 0);

        // Reset mid-stream with a push active
        set_lanes(1, 1, 1, 10'd300, 10'd301, 10'd302, 5'b01000, 0, 0);
        tick();
        set_lanes(1, 1, 0, 10'd303, 10'd304, 0, 0, 0, 0);
        tick();
        check("t6_cnt5", 32'(count), 5);
        rst = 1'b1;
        set_lanes(1, 0, 0, 10'd305, 0, 0, 5'b11111, 0, 0);
        tick();
        rst = 1'b0; clear_lanes();
        check("t6_count", 32'(count), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_flags", 32'(fl_sticky), 0);
        check("t6_ovf",   32'(ovf), 0);
        check("t6_stall", 32'(stall), 0);

`ifdef FPU_RET_BYPASS_EN
        // Lone completion into an empty FIFO is visible and retired at once
        out_ready = 1'b1;
        set_lanes(0, 1, 0, 0, 10'd33, 0, 0, 5'b01000, 0);
        #1;
        check("byp_valid", 32'(out_valid), 1);
        check("byp_II",    32'(out_II), 33);
        check("byp_unit",  32'(out_unit), 1);
        tick();
        clear_lanes();
        out_ready = 1'b0;
        check("byp_count", 32'(count), 0);
        check("byp_flags", 32'(fl_sticky), 32'(5'b01000));
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
